// File: rtl/i2cmb_wb_sequencer.sv
// rtl/i2cmb_wb_sequencer.sv - request-driven I2C transaction sequencer mastering an IICMB core over Wishbone
//
// Purpose: accepts single-byte I2C read/write requests, queues them, and walks
// the IICMB command sequence (SetBus, Start, address, data, Stop) over a
// Wishbone master port, returning one response per request.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*               request stream (valid/ready): bus, 7-bit addr, rw (1=read), write byte
//   rsp_*               response stream (valid/ready): read byte, status (00 ok, 01 NAK, 10 arb lost, 11 error)
//   busy                high unless idle with no queued request
//   cyc_o..dat_o        Wishbone master outputs (stb_o mirrors cyc_o)
//   dat_i, ack_i        Wishbone read data / acknowledge
//   irq_i               IICMB interrupt (only used when I2CMB_SEQ_IRQ_EN is defined)
//
// Build option: define I2CMB_SEQ_IRQ_EN to enable the IICMB interrupt and
// wait on irq_i instead of polling CMDR for the done bit.

module i2cmb_seq_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] s_tdata,
   input  logic         s_tvalid,
   output logic         s_tready,
   output logic [W-1:0] m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         full;
   logic         push;
   logic         pop;

   // Extra pointer bit distinguishes full from empty.
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign s_tready = !full;
   assign m_tvalid = (wr_ptr != rd_ptr);
   assign push     = s_tvalid && s_tready;
   assign pop      = m_tready && m_tvalid;
   assign m_tdata  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
   end
endmodule

module i2cmb_wb_sequencer #(
   parameter int NUM_I2C_BUSSES = 1,
   parameter int FIFO_DEPTH     = 4,
   parameter int BUS_ID_W       = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [BUS_ID_W-1:0] req_bus,
   input  logic [6:0]          req_addr,
   input  logic                req_rw,
   input  logic [7:0]          req_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [7:0]          rsp_data,
   output logic [1:0]          rsp_status,
   output logic                busy,
   output logic                cyc_o,
   output logic                stb_o,
   output logic                we_o,
   output logic [1:0]          adr_o,
   output logic [7:0]          dat_o,
   input  logic [7:0]          dat_i,
   input  logic                ack_i,
   input  logic                irq_i
);
   localparam logic [1:0] ADR_CSR  = 2'd0;
   localparam logic [1:0] ADR_DPR  = 2'd1;
   localparam logic [1:0] ADR_CMDR = 2'd2;

   localparam logic [7:0] CMD_WRITE   = 8'h01;
   localparam logic [7:0] CMD_READNAK = 8'h03;
   localparam logic [7:0] CMD_START   = 8'h04;
   localparam logic [7:0] CMD_STOP    = 8'h05;
   localparam logic [7:0] CMD_SETBUS  = 8'h06;

`ifdef I2CMB_SEQ_IRQ_EN
   localparam logic [7:0] CSR_INIT = 8'hC0;
   localparam bit         IRQ_MODE = 1'b1;
`else
   localparam logic [7:0] CSR_INIT = 8'h80;
   localparam bit         IRQ_MODE = 1'b0;
`endif

   localparam int                REQ_W   = BUS_ID_W + 16;
   localparam logic [BUS_ID_W:0] NUM_BUS = (BUS_ID_W + 1)'(NUM_I2C_BUSSES);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_SETBUS, S_START, S_ADDR, S_DATA, S_STOP, S_RESP
   } state_t;

   // Sub-steps of one IICMB command: optional DPR write, CMDR write, wait for
   // done; PH_RDDPR fetches the received byte after a ReadNak completes.
   typedef enum logic [1:0] {PH_DPR, PH_CMD, PH_WAIT, PH_RDDPR} phase_t;

   state_t              state, state_nxt;
   phase_t              phase, phase_nxt;
   logic [BUS_ID_W-1:0] cur_bus, cur_bus_nxt;
   logic [6:0]          cur_addr, cur_addr_nxt;
   logic                cur_rw, cur_rw_nxt;
   logic [7:0]          cur_data, cur_data_nxt;
   logic [BUS_ID_W-1:0] last_bus, last_bus_nxt;
   logic                last_bus_vld, last_bus_vld_nxt;
   logic                cyc_nxt, we_nxt;
   logic [1:0]          adr_nxt;
   logic [7:0]          dat_nxt;
   logic [7:0]          rsp_data_nxt;
   logic [1:0]          rsp_status_nxt;

   logic                fifo_s_tready;
   logic                fifo_m_tvalid;
   logic                fifo_pop;
   logic [REQ_W-1:0]    fifo_m_tdata;
   logic [BUS_ID_W-1:0] hd_bus;
   logic [6:0]          hd_addr;
   logic                hd_rw;
   logic [7:0]          hd_data;

   logic                wb_done;
   logic                wait_go;
   logic                launch;
   logic                l_we;
   logic [1:0]          l_adr;
   logic [7:0]          l_dat;
   logic [7:0]          step_dpr;
   logic [7:0]          step_cmd;

   i2cmb_seq_fifo #(.W(REQ_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .s_tdata  ({req_bus, req_addr, req_rw, req_data}),
      .s_tvalid (req_valid),
      .s_tready (fifo_s_tready),
      .m_tdata  (fifo_m_tdata),
      .m_tvalid (fifo_m_tvalid),
      .m_tready (fifo_pop)
   );

   assign {hd_bus, hd_addr, hd_rw, hd_data} = fifo_m_tdata;

   assign req_ready = fifo_s_tready && !rst_i;
   assign busy      = !rst_i && !((state == S_IDLE) && !fifo_m_tvalid);
   assign rsp_valid = (state == S_RESP);
   assign stb_o     = cyc_o;
   assign wb_done   = cyc_o && ack_i;
   assign wait_go   = !IRQ_MODE || irq_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_INIT;
         phase        <= PH_DPR;
         cur_bus      <= '0;
         cur_addr     <= '0;
         cur_rw       <= 1'b0;
         cur_data     <= '0;
         last_bus     <= '0;
         last_bus_vld <= 1'b0;
         cyc_o        <= 1'b0;
         we_o         <= 1'b0;
         adr_o        <= '0;
         dat_o        <= '0;
         rsp_data     <= '0;
         rsp_status   <= '0;
      end else begin
         state        <= state_nxt;
         phase        <= phase_nxt;
         cur_bus      <= cur_bus_nxt;
         cur_addr     <= cur_addr_nxt;
         cur_rw       <= cur_rw_nxt;
         cur_data     <= cur_data_nxt;
         last_bus     <= last_bus_nxt;
         last_bus_vld <= last_bus_vld_nxt;
         cyc_o        <= cyc_nxt;
         we_o         <= we_nxt;
         adr_o        <= adr_nxt;
         dat_o        <= dat_nxt;
         rsp_data     <= rsp_data_nxt;
         rsp_status   <= rsp_status_nxt;
      end
   end

   always_comb begin
      step_dpr = 8'h00;
      step_cmd = 8'h00;
      case (state)
         S_SETBUS: begin step_dpr = 8'(cur_bus);          step_cmd = CMD_SETBUS; end
         S_START:  begin                                   step_cmd = CMD_START;  end
         S_ADDR:   begin step_dpr = {cur_addr, cur_rw};   step_cmd = CMD_WRITE;  end
         S_DATA:   begin step_dpr = cur_data;
                         step_cmd = cur_rw ? CMD_READNAK : CMD_WRITE;             end
         S_STOP:   begin                                   step_cmd = CMD_STOP;   end
         default:  ;
      endcase
   end

   always_comb begin
      state_nxt        = state;
      phase_nxt        = phase;
      cur_bus_nxt      = cur_bus;
      cur_addr_nxt     = cur_addr;
      cur_rw_nxt       = cur_rw;
      cur_data_nxt     = cur_data;
      last_bus_nxt     = last_bus;
      last_bus_vld_nxt = last_bus_vld;
      cyc_nxt          = cyc_o;
      we_nxt           = we_o;
      adr_nxt          = adr_o;
      dat_nxt          = dat_o;
      rsp_data_nxt     = rsp_data;
      rsp_status_nxt   = rsp_status;
      fifo_pop         = 1'b0;
      launch           = 1'b0;
      l_we             = 1'b0;
      l_adr            = ADR_CSR;
      l_dat            = 8'h00;

      // Every bus signal returns to zero the cycle after ack, which also
      // guarantees one idle cycle before the next access can launch.
      if (wb_done) begin
         cyc_nxt = 1'b0;
         we_nxt  = 1'b0;
         adr_nxt = '0;
         dat_nxt = '0;
      end

      case (state)
         S_INIT: begin
            if (!cyc_o) begin
               launch = 1'b1;
               l_we   = 1'b1;
               l_adr  = ADR_CSR;
               l_dat  = CSR_INIT;
            end
            if (wb_done) state_nxt = S_IDLE;
         end

         S_IDLE: begin
            if (fifo_m_tvalid) begin
               fifo_pop       = 1'b1;
               cur_bus_nxt    = hd_bus;
               cur_addr_nxt   = hd_addr;
               cur_rw_nxt     = hd_rw;
               cur_data_nxt   = hd_data;
               rsp_data_nxt   = 8'h00;
               rsp_status_nxt = 2'b00;
               if ({1'b0, hd_bus} >= NUM_BUS) begin
                  rsp_status_nxt = 2'b11;
                  state_nxt      = S_RESP;
               end else if (last_bus_vld && (hd_bus == last_bus)) begin
                  state_nxt = S_START;
                  phase_nxt = PH_CMD;
               end else begin
                  state_nxt = S_SETBUS;
                  phase_nxt = PH_DPR;
               end
            end
         end

         S_SETBUS, S_START, S_ADDR, S_DATA, S_STOP: begin
            case (phase)
               PH_DPR: begin
                  if (!cyc_o) begin
                     launch = 1'b1;
                     l_we   = 1'b1;
                     l_adr  = ADR_DPR;
                     l_dat  = step_dpr;
                  end
                  if (wb_done) phase_nxt = PH_CMD;
               end

               PH_CMD: begin
                  if (!cyc_o) begin
                     launch = 1'b1;
                     l_we   = 1'b1;
                     l_adr  = ADR_CMDR;
                     l_dat  = step_cmd;
                  end
                  if (wb_done) phase_nxt = PH_WAIT;
               end

               PH_WAIT: begin
                  // Polling mode re-reads CMDR until DON; irq mode issues
                  // the read only once the interrupt is raised.
                  if (!cyc_o && wait_go) begin
                     launch = 1'b1;
                     l_adr  = ADR_CMDR;
                  end
                  if (wb_done && dat_i[7]) begin
                     if (dat_i[5] || dat_i[4]) begin
                        // Lost arbitration or core error: the bus state is
                        // unknown, so skip Stop and force a SetBus next time.
                        rsp_status_nxt   = dat_i[5] ? 2'b10 : 2'b11;
                        rsp_data_nxt     = 8'h00;
                        last_bus_vld_nxt = 1'b0;
                        state_nxt        = S_RESP;
                     end else begin
                        case (state)
                           S_SETBUS: begin
                              last_bus_nxt     = cur_bus;
                              last_bus_vld_nxt = 1'b1;
                              state_nxt        = S_START;
                              phase_nxt        = PH_CMD;
                           end
                           S_START: begin
                              state_nxt = S_ADDR;
                              phase_nxt = PH_DPR;
                           end
                           S_ADDR: begin
                              if (dat_i[6]) begin
                                 rsp_status_nxt = 2'b01;
                                 state_nxt      = S_STOP;
                                 phase_nxt      = PH_CMD;
                              end else begin
                                 state_nxt = S_DATA;
                                 phase_nxt = cur_rw ? PH_CMD : PH_DPR;
                              end
                           end
                           S_DATA: begin
                              if (dat_i[6]) begin
                                 rsp_status_nxt = 2'b01;
                                 state_nxt      = S_STOP;
                                 phase_nxt      = PH_CMD;
                              end else if (cur_rw) begin
                                 phase_nxt = PH_RDDPR;
                              end else begin
                                 state_nxt = S_STOP;
                                 phase_nxt = PH_CMD;
                              end
                           end
                           S_STOP:  state_nxt = S_RESP;
                           default: ;
                        endcase
                     end
                  end
               end

               PH_RDDPR: begin
                  if (!cyc_o) begin
                     launch = 1'b1;
                     l_adr  = ADR_DPR;
                  end
                  if (wb_done) begin
                     rsp_data_nxt = dat_i;
                     state_nxt    = S_STOP;
                     phase_nxt    = PH_CMD;
                  end
               end

               default: ;
            endcase
         end

         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end

         default: state_nxt = S_INIT;
      endcase

      if (launch) begin
         cyc_nxt = 1'b1;
         we_nxt  = l_we;
         adr_nxt = l_adr;
         dat_nxt = l_dat;
      end
   end
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// tb/tb_i2cmb_wb_sequencer.sv - self-checking bench for i2cmb_wb_sequencer with an IICMB bus model
//
// Purpose: drives directed and randomized requests, emulates the IICMB core on
// the Wishbone side, and compares the logged Wishbone traffic and responses
// against a transaction-level reference model.
//
// Ports: none (top-level bench).

module tb_i2cmb_wb_sequencer;
   localparam int NB = 4;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_bus = '0;
   logic [6:0] req_addr = '0;
   logic       req_rw = 1'b0;
   logic [7:0] req_data = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic [1:0] rsp_status;
   logic       busy;
   logic       cyc_o, stb_o, we_o;
   logic [1:0] adr_o;
   logic [7:0] dat_o;
   logic [7:0] dat_i = '0;
   logic       ack_i = 1'b0;
   logic       irq_i = 1'b0;

   always #5 clk = ~clk;

   i2cmb_wb_sequencer #(.NUM_I2C_BUSSES(NB), .FIFO_DEPTH(4), .BUS_ID_W(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus),
      .req_addr(req_addr), .req_rw(req_rw), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_status(rsp_status), .busy(busy),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Environment seen by both the IICMB model and the reference model.
   bit         present [128];
   bit         al_inject = 1'b0;
   logic [7:0] slave_rd = 8'h3C;

   // Wishbone op log entries: {we, adr[1:0], data}; CMDR status polls are not logged.
   logic [10:0] log_q [$];
   logic [10:0] exp_q [$];
   logic [9:0]  exp_rsp_q [$];
   int          cyc_count = 0;
   int          viol_count = 0;

   function automatic logic [10:0] mk(input logic we, input logic [1:0] adr, input logic [7:0] d);
      return {we, adr, d};
   endfunction

   // ---------------- IICMB emulation ----------------
   logic [7:0] emu_dpr = '0;
   logic       emu_nak = 1'b0, emu_al = 1'b0, emu_err = 1'b0;
   int         emu_poll = 0;
   bit         emu_after_start = 1'b0;

   task automatic emu_cmd(input logic [7:0] c);
      emu_nak  = 1'b0;
      emu_al   = 1'b0;
      emu_err  = 1'b0;
      emu_poll = $urandom_range(0, 3);
      case (c)
         8'h06: begin emu_err = (emu_dpr >= NB); emu_after_start = 1'b0; end
         8'h04: begin
            if (al_inject) begin emu_al = 1'b1; al_inject = 1'b0; end
            else emu_after_start = 1'b1;
         end
         8'h01: begin
            if (emu_after_start) begin
               emu_after_start = 1'b0;
               emu_nak = !present[emu_dpr[7:1]];
            end
         end
         8'h03: emu_dpr = slave_rd;
         8'h05: emu_after_start = 1'b0;
         default: emu_err = 1'b1;
      endcase
   endtask

   task automatic emu_access();
      if (we_o) begin
         if (adr_o == 2'd1) emu_dpr = dat_o;
         log_q.push_back(mk(1'b1, adr_o, dat_o));
         if (adr_o == 2'd2) emu_cmd(dat_o);
      end else if (adr_o == 2'd2) begin
         if (emu_poll > 0) begin dat_i = 8'h00; emu_poll--; end
         else dat_i = {1'b1, emu_nak, emu_al, emu_err, 4'h0};
      end else if (adr_o == 2'd1) begin
         dat_i = emu_dpr;
         log_q.push_back(mk(1'b0, 2'd1, emu_dpr));
      end else begin
         dat_i = 8'h00;
      end
   endtask

   initial begin
      logic       prev_cyc = 1'b0;
      logic [10:0] prev_sig = '0;
      bit         in_acc = 1'b0;
      int         wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (stb_o !== cyc_o) viol_count++;
         if (ack_i && cyc_o) viol_count++;
         if (!ack_i && prev_cyc && cyc_o && ({we_o, adr_o, dat_o} != prev_sig)) viol_count++;
         if (!cyc_o && (we_o || adr_o != 2'd0 || dat_o != 8'd0)) viol_count++;
         if (cyc_o && !prev_cyc) cyc_count++;
         prev_cyc = cyc_o;
         prev_sig = {we_o, adr_o, dat_o};
         if (ack_i) begin
            ack_i  = 1'b0;
            in_acc = 1'b0;
         end else if (cyc_o) begin
            if (!in_acc) begin in_acc = 1'b1; wait_cnt = $urandom_range(0, 2); end
            if (wait_cnt == 0) begin ack_i = 1'b1; emu_access(); end
            else wait_cnt--;
         end else begin
            in_acc = 1'b0;
         end
      end
   end

   // ---------------- reference model ----------------
   bit         m_vld = 1'b0;
   logic [3:0] m_bus = '0;

   task automatic model_req(input logic [3:0] bus, input logic [6:0] addr, input logic rw,
                            input logic [7:0] data, input bit al);
      if (bus >= NB) begin exp_rsp_q.push_back({2'd3, 8'h00}); return; end
      if (!(m_vld && m_bus == bus)) begin
         exp_q.push_back(mk(1, 1, {4'h0, bus}));
         exp_q.push_back(mk(1, 2, 8'h06));
         m_vld = 1'b1;
         m_bus = bus;
      end
      exp_q.push_back(mk(1, 2, 8'h04));
      if (al) begin m_vld = 1'b0; exp_rsp_q.push_back({2'd2, 8'h00}); return; end
      exp_q.push_back(mk(1, 1, {addr, rw}));
      exp_q.push_back(mk(1, 2, 8'h01));
      if (!present[addr]) begin
         exp_q.push_back(mk(1, 2, 8'h05));
         exp_rsp_q.push_back({2'd1, 8'h00});
         return;
      end
      if (rw) begin
         exp_q.push_back(mk(1, 2, 8'h03));
         exp_q.push_back(mk(0, 1, slave_rd));
         exp_q.push_back(mk(1, 2, 8'h05));
         exp_rsp_q.push_back({2'd0, slave_rd});
      end else begin
         exp_q.push_back(mk(1, 1, data));
         exp_q.push_back(mk(1, 2, 8'h01));
         exp_q.push_back(mk(1, 2, 8'h05));
         exp_rsp_q.push_back({2'd0, 8'h00});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_req(input logic [3:0] bus, input logic [6:0] addr, input logic rw,
                           input logic [7:0] data, input bit al);
      int n = 0;
      if (al) al_inject = 1'b1;
      @(negedge clk);
      req_bus = bus; req_addr = addr; req_rw = rw; req_data = data; req_valid = 1'b1;
      while (!req_ready && n < 2000) begin @(negedge clk); n++; end
      if (!req_ready) begin
         check_eq("req_accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      model_req(bus, addr, rw, data, al);
   endtask

   task automatic get_rsp(input int max_delay);
      logic [9:0] e;
      int n = 0;
      repeat ($urandom_range(0, max_delay)) @(negedge clk);
      @(negedge clk);
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
      if (!rsp_valid) begin
         check_eq("rsp_timeout", 0, 1);
         rsp_ready = 1'b0;
         return;
      end
      if (exp_rsp_q.size() == 0) begin
         check_eq("rsp_unexpected", 1, 0);
      end else begin
         e = exp_rsp_q.pop_front();
         check_eq("rsp_status", rsp_status, e[9:8]);
         check_eq("rsp_data", rsp_data, e[7:0]);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic compare_log(input string tag);
      int n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      check_eq({tag, "_len"}, log_q.size(), exp_q.size());
      for (int i = 0; i < n; i++) check_eq($sformatf("%s_op%0d", tag, i), log_q[i], exp_q[i]);
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_log(input int cnt);
      int n = 0;
      while (log_q.size() < cnt && n < 200) begin @(negedge clk); n++; end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int  c0, n, seen;
      logic [3:0] b;
      logic [6:0] a;
      logic [1:0] r;
      bit  al;

      present[7'h22] = 1'b1;
      present[7'h30] = 1'b1;
      present[7'h5A] = 1'b1;

      repeat (3) @(negedge clk);
      check_eq("rst_cyc_stb_we", {cyc_o, stb_o, we_o}, 3'b000);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_adr_dat", {adr_o, dat_o}, 0);
      check_eq("rst_rsp_fields", {rsp_data, rsp_status}, 0);

      exp_q.push_back(mk(1, 0, 8'h80));
      rst_i = 1'b0;
      wait_log(1);
      repeat (3) @(negedge clk);
      compare_log("init");
      check_eq("idle_busy", busy, 0);
      check_eq("idle_req_ready", req_ready, 1);

      // Write bus 0 addr 0x22 data 0xA5
      send_req(4'd0, 7'h22, 1'b0, 8'hA5, 1'b0);
      check_eq("busy_active", busy, 1);
      get_rsp(0);
      compare_log("write");

      // Read on same bus, SetBus skipped
      slave_rd = 8'h3C;
      send_req(4'd0, 7'h22, 1'b1, 8'h00, 1'b0);
      get_rsp(3);
      compare_log("read");

      // No slave at 0x11, then same bus succeeds
      send_req(4'd0, 7'h11, 1'b0, 8'h5E, 1'b0);
      get_rsp(3);
      compare_log("nak");
      send_req(4'd0, 7'h22, 1'b0, 8'h77, 1'b0);
      get_rsp(0);
      compare_log("after_nak");

      // Out-of-range bus
      c0 = cyc_count;
      send_req(4'(NB), 7'h22, 1'b0, 8'h00, 1'b0);
      get_rsp(2);
      check_eq("badbus_cyc", cyc_count - c0, 0);
      compare_log("badbus");

      // Fill the FIFO while a response is held
      send_req(4'd1, 7'h30, 1'b0, 8'h11, 1'b0);
      n = 0;
      while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
      check_eq("hold_rsp_valid", rsp_valid, 1);
      send_req(4'd1, 7'h30, 1'b1, 8'h00, 1'b0);
      send_req(4'd2, 7'h5A, 1'b0, 8'h42, 1'b0);
      send_req(4'd2, 7'h11, 1'b1, 8'h00, 1'b0);
      send_req(4'd0, 7'h22, 1'b0, 8'h24, 1'b0);
      @(negedge clk);
      check_eq("full_req_ready", req_ready, 0);
      req_bus = 4'd3; req_addr = 7'h22; req_rw = 1'b0; req_data = 8'hEE; req_valid = 1'b1;
      seen = 0;
      repeat (8) begin @(negedge clk); if (req_ready) seen++; end
      req_valid = 1'b0;
      check_eq("fifth_rejected", seen, 0);
      check_eq("rsp_held", {rsp_valid, rsp_status}, {1'b1, 2'b00});
      repeat (5) get_rsp(2);
      compare_log("fifo");
      repeat (20) @(negedge clk);
      check_eq("drained_rsp_valid", rsp_valid, 0);
      check_eq("drained_busy", busy, 0);

      // Arbitration lost on Start, next request reissues SetBus
      send_req(4'd0, 7'h22, 1'b0, 8'h99, 1'b1);
      get_rsp(0);
      compare_log("al");
      slave_rd = 8'hC3;
      send_req(4'd0, 7'h22, 1'b1, 8'h00, 1'b0);
      get_rsp(0);
      compare_log("after_al");

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         b = ($urandom_range(0, 9) == 0) ? 4'(NB) : 4'($urandom_range(0, NB - 1));
         r = 2'($urandom_range(0, 3));
         case (r)
            2'd0: a = 7'h22;
            2'd1: a = 7'h11;
            2'd2: a = 7'h30;
            default: a = 7'($urandom_range(0, 127));
         endcase
         al = (b < NB) && ($urandom_range(0, 7) == 0);
         slave_rd = 8'($urandom);
         send_req(b, a, 1'($urandom_range(0, 1)), 8'($urandom), al);
         get_rsp(5);
         compare_log("rand");
      end

      // Reset during the data phase of a write
      send_req(4'd1, 7'h22, 1'b0, 8'hD7, 1'b0);
      n = 0;
      while (!(cyc_o && we_o && adr_o == 2'd1 && dat_o == 8'hD7) && n < 2000) begin
         @(negedge clk); n++;
      end
      check_eq("data_phase_seen", {cyc_o, dat_o}, {1'b1, 8'hD7});
      rst_i = 1'b1;
      @(posedge clk);
      #1 check_eq("rst_mid_cyc", {cyc_o, stb_o}, 2'b00);
      @(negedge clk);
      rst_i = 1'b0;
      log_q.delete();
      exp_q.delete();
      exp_rsp_q.delete();
      m_vld = 1'b0;
      al_inject = 1'b0;
      emu_after_start = 1'b0;
      exp_q.push_back(mk(1, 0, 8'h80));
      seen = 0;
      repeat (30) begin @(negedge clk); if (rsp_valid) seen++; end
      check_eq("rst_no_rsp", seen, 0);
      compare_log("reinit");

      slave_rd = 8'h5B;
      send_req(4'd2, 7'h30, 1'b1, 8'h00, 1'b0);
      get_rsp(1);
      compare_log("post_rst");

      check_eq("wb_protocol_viol", viol_count, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2cmb_wb_sequencer.md
I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

Interface
REQ-001 SHALL have parameters: NUM_I2C_BUSSES, 1, busses behind IICMB (1..16); FIFO_DEPTH, 4, request FIFO entries (power of 2); BUS_ID_W, 4, req_bus width.
REQ-002 SHALL have ports (clock and reset first): clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high.
REQ-003 SHALL have request ports: req_valid in 1; req_ready out 1; req_bus in BUS_ID_W; req_addr in 7 slave addr; req_rw in 1 (1=read); req_data in 8 write byte.
REQ-004 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_data out 8 read byte; rsp_status out 2 (00 ok, 01 NAK, 10 arb lost, 11 error); busy out 1.
REQ-005 SHALL have Wishbone master ports: cyc_o, stb_o, we_o out 1; adr_o out 2; dat_o out 8; dat_i in 8; ack_i in 1; irq_i in 1.

Function
REQ-006 SHALL buffer requests in a FIFO_DEPTH FIFO; req_ready = not full; push when req_valid&&req_ready; pop same cycle as push when full SHALL NOT admit the push.
REQ-007 SHALL run each WB access as: cyc_o/stb_o/we_o/adr_o/dat_o asserted and held until ack_i, all deasserted the cycle after ack_i; at most one access outstanding; no back-to-back cycle without one idle cycle.
REQ-008 SHALL use IICMB offsets CSR=0, DPR=1, CMDR=2; commands Write=0x01, ReadNak=0x03, Start=0x04, Stop=0x05, SetBus=0x06; CMDR response bits DON=7, NAK=6, AL=5, ERR=4.
REQ-009 SHALL have states INIT, IDLE, SETBUS, START, ADDR, DATA, STOP, RESP; each command step = optional DPR write, CMDR write, WAIT_DONE.
REQ-010 INIT SHALL write CSR once after reset, then go IDLE.
REQ-011 IDLE SHALL pop the FIFO head when not empty and go SETBUS, or START if req_bus equals the last successfully set bus.
REQ-012 A request with req_bus >= NUM_I2C_BUSSES SHALL produce rsp_status 11 in RESP with no WB activity.
REQ-013 SETBUS: DPR<=req_bus, CMDR<=0x06; START: CMDR<=0x04; ADDR: DPR<={req_addr,req_rw}, CMDR<=0x01.
REQ-014 DATA write: DPR<=req_data, CMDR<=0x01; DATA read: CMDR<=0x03 then DPR read, rsp_data<=dat_i.
REQ-015 STOP: CMDR<=0x05, then RESP with status 00.
REQ-016 Done status NAK on ADDR or DATA SHALL go STOP and report 01; AL SHALL go RESP directly (no Stop) with 10 and invalidate last bus; ERR SHALL go RESP with 11 and invalidate last bus.
REQ-017 RESP SHALL hold rsp_valid and rsp_data/rsp_status stable until rsp_ready; next pop only after handshake; rsp_data=0x00 for writes and failures.
REQ-018 busy SHALL be 1 in every state except IDLE with empty FIFO.

Reset
REQ-019 rst_i SHALL clear FIFO, invalidate last bus, enter INIT; cyc_o, stb_o, we_o, req_ready, rsp_valid, busy = 0, adr_o, dat_o, rsp_data, rsp_status = 0.
REQ-020 rst_i mid-cycle SHALL drop cyc_o/stb_o the next edge and abandon the transaction without response.

Configuration
REQ-021 Macro I2CMB_SEQ_IRQ_EN defined: INIT writes CSR=0xC0; WAIT_DONE waits for irq_i=1, then one CMDR read to capture status and clear irq.
REQ-022 Macro absent: INIT writes CSR=0x80; WAIT_DONE reads CMDR repeatedly until bit 7 = 1; irq_i ignored.

Verification
REQ-023 Write: bus 0, addr 0x22, data 0xA5 -> WB writes CSR, DPR 0x00, CMDR 0x06, CMDR 0x04, DPR 0x44, CMDR 0x01, DPR 0xA5, CMDR 0x01, CMDR 0x05; rsp 00, data 0x00.
REQ-024 Read: second request bus 0, addr 0x22, slave returns 0x3C -> SetBus skipped, DPR 0x45, CMDR 0x03, DPR read; rsp 00, data 0x3C.
REQ-025 No slave at addr 0x11 -> NAK after ADDR; Stop issued; rsp 01; next request on same bus succeeds.
REQ-026 req_bus=NUM_I2C_BUSSES -> rsp 11 with zero cyc_o cycles; FIFO full (4 pushes, rsp_ready=0) -> req_ready=0, fifth push rejected.
REQ-027 AL forced on START -> rsp 10, no Stop; next request reissues SetBus; rst_i during DATA -> cyc_o=0 next cycle, rsp_valid stays 0, INIT CSR rewrite.
